comet_uart_tx_port: RTL and testbench

//  Memory-mapped serial transmit peripheral that responds to COMET II CPU bus cycles (re/raddr/rdata, we/waddr/wdata).
//  It sits beside the program RAM on the same bus and claims a small address window; the top level muxes rdata on rd_hit.
//  CPU writes bytes into a TX FIFO; an 8N1 serializer drains the FIFO onto the tx pin at a divided bit rate.

---
 rtl/comet_uart_tx_port_pkg.sv | 41 ++++
 rtl/comet_uart_tx_port_fifo.sv | 50 +++++
 rtl/comet_uart_tx_port.sv | 171 +++++++++++++++++
 tb/tb_comet_uart_tx_port.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/comet_uart_tx_port_pkg.sv
// Shared definitions for the COMET II serial transmit peripheral:
// register offsets, STATUS/CTRL bit positions, serializer states, address decode.
package comet_uart_tx_port_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] off;
    } bus_dec_t;

    // Subtracting the base keeps the window correct even for an unaligned BASE_ADDR.
    function automatic bus_dec_t decode(input logic [15:0] addr, input logic [15:0] base);
        bus_dec_t   d;
        logic [15:0] off;
        off   = addr - base;
        d.hit = (off[15:2] == 14'd0);
        d.off = off[1:0];
        return d;
    endfunction

endpackage

// File: rtl/comet_uart_tx_port_fifo.sv
// Single-clock FIFO with show-ahead read data; a pop in the same cycle
// frees the slot, so a push into a full FIFO is accepted when paired with a pop.
module comet_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/comet_uart_tx_port.sv
// Memory-mapped 8N1 transmitter on the COMET II bus: register file and decode,
// TX FIFO, and a serializer that chains frames with no idle gap between them.
module comet_uart_tx_port
    import comet_uart_tx_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          CLK_DIV   = 139,
    parameter int          FIFO_AW   = 3
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        re,
    input  logic [15:0] raddr,
    output logic [15:0] rdata,
    output logic        rd_hit,
    input  logic        we,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    output logic        tx,
    output logic        irq
);
    localparam logic [15:0] TIMER_MAX = 16'(CLK_DIV - 1);

    bus_dec_t         rd_dec, wr_dec;
    logic             wr_push, ctrl_wr, st_rd, overflow;
    logic [1:0]       ctrl;
    logic             ovf;
    logic [15:0]      status, rd_val;
    logic             full, empty, pop, busy;
    logic [FIFO_AW:0] count;
    logic [7:0]       fifo_q;

    tx_state_t   state, state_n;
    logic [15:0] timer, timer_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        tx_n, bit_end, start_ok;

    logic unused_wdata;
    assign unused_wdata = ^wdata[15:8];

    assign rd_dec   = decode(raddr, BASE_ADDR);
    assign wr_dec   = decode(waddr, BASE_ADDR);
    assign wr_push  = we && wr_dec.hit && (wr_dec.off == REG_TXDATA);
    assign ctrl_wr  = we && wr_dec.hit && (wr_dec.off == REG_CTRL);
    assign st_rd    = re && rd_dec.hit && (rd_dec.off == REG_STATUS);
    assign overflow = wr_push && full && !pop;
    assign busy     = (state != S_IDLE);
    assign irq      = empty && !busy && ctrl[CTRL_IE];

    always_comb begin
        status                              = '0;
        status[ST_FULL]                     = full;
        status[ST_EMPTY]                    = empty;
        status[ST_BUSY]                     = busy;
        status[ST_OVF]                      = ovf;
        status[ST_CNT_LSB +: FIFO_AW+1]     = count;
    end

    always_comb begin
        rd_val = '0;
        case (rd_dec.off)
            REG_STATUS: rd_val = status;
            REG_CTRL:   rd_val = {14'h0, ctrl};
            default:    rd_val = '0;
        endcase
    end

    // Overflow wins over a same-cycle STATUS read so a drop is never lost.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rd_hit <= 1'b0;
            ctrl   <= 2'b01;
            ovf    <= 1'b0;
        end else begin
            rd_hit <= re && rd_dec.hit;
            rdata  <= (re && rd_dec.hit) ? rd_val : '0;
            if (ctrl_wr) ctrl <= wdata[1:0];
            if (overflow)   ovf <= 1'b1;
            else if (st_rd) ovf <= 1'b0;
        end
    end

    comet_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
        .clk   (mclk),
        .rst_n (rst_n),
        .push  (wr_push),
        .pop   (pop),
        .wdata (wdata[7:0]),
        .rdata (fifo_q),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bit_end  = (timer == TIMER_MAX);
    assign start_ok = ctrl[CTRL_EN] && !empty;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
        end
    end

    // End of STOP may launch the next START directly to keep frames contiguous.
    always_comb begin
        state_n = state;
        timer_n = timer;
        bit_n   = bit_idx;
        shreg_n = shreg;
        tx_n    = tx;
        pop     = 1'b0;
        if (state != S_IDLE) timer_n = bit_end ? '0 : timer + 16'd1;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    pop     = 1'b1;
                    shreg_n = fifo_q;
                    tx_n    = 1'b0;
                    timer_n = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                    shreg_n = {1'b0, shreg[7:1]};
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        tx_n    = shreg[0];
                        shreg_n = {1'b0, shreg[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (start_ok) begin
                        pop     = 1'b1;
                        shreg_n = fifo_q;
                        tx_n    = 1'b0;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_comet_uart_tx_port.sv
// Scoreboard bench: stimulus queues expected reads and serial frames, monitors
// pop and compare when rd_hit timing or a tx start bit presents an output.
module tb_comet_uart_tx_port;
    localparam logic [15:0] BASE = 16'hFF00;
    localparam int          DIV  = 4;
    localparam int          FLEN = 10 * DIV;

    logic        mclk = 1'b0, rst_n = 1'b0, re = 1'b0, we = 1'b0;
    logic [15:0] raddr = '0, waddr = '0, wdata = '0;
    logic [15:0] rdata;
    logic        rd_hit, tx, irq;

    int     errors = 0, checks = 0;
    longint cyc = 0;

    typedef struct { logic hit; logic [15:0] data; } rd_exp_t;
    typedef struct { logic [7:0] data; bit b2b; } tx_exp_t;
    rd_exp_t rd_q[$];
    tx_exp_t tx_q[$];

    comet_uart_tx_port #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_AW(3)) dut (
        .mclk(mclk), .rst_n(rst_n), .re(re), .raddr(raddr), .rdata(rdata), .rd_hit(rd_hit),
        .we(we), .waddr(waddr), .wdata(wdata), .tx(tx), .irq(irq)
    );

    always #5 mclk = ~mclk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    logic re_seen = 1'b0;
    always @(posedge mclk) begin
        cyc     <= cyc + 1;
        re_seen <= re;
    end

    // Read monitor: a read issued last cycle must show up now, otherwise outputs idle at zero.
    always @(negedge mclk) begin
        rd_exp_t e;
        if (re_seen) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got hit=%b data=%h with no read queued", rd_hit, rdata);
            end else begin
                e = rd_q.pop_front();
                check("rd_hit", 64'(rd_hit), 64'(e.hit));
                check("rdata", 64'(rdata), 64'(e.data));
            end
        end else begin
            check("rd_idle", 64'({rd_hit, rdata}), 64'h0);
        end
    end

    // Serial monitor: capture 40 samples from the start bit and compare the whole waveform.
    bit          in_frame = 0;
    int          pos = 0;
    logic [39:0] samp;
    longint      prev_start = -1000;
    always @(negedge mclk) begin
        tx_exp_t     e;
        logic [39:0] expw;
        if (!rst_n) begin
            in_frame = 0;
        end else if (in_frame) begin
            samp[pos] = tx;
            pos++;
            if (pos == FLEN) begin
                in_frame = 0;
                if (tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got frame %h with no byte queued", samp);
                end else begin
                    e = tx_q.pop_front();
                    for (int i = 0; i < FLEN; i++) begin
                        if (i / DIV == 0)      expw[i] = 1'b0;
                        else if (i / DIV == 9) expw[i] = 1'b1;
                        else                   expw[i] = e.data[i/DIV - 1];
                    end
                    check("tx_frame", 64'(samp), 64'(expw));
                end
            end
        end else if (tx == 1'b0) begin
            in_frame = 1;
            samp[0]  = 1'b0;
            pos      = 1;
            if (tx_q.size() > 0 && tx_q[0].b2b) check("tx_gap", 64'(cyc - prev_start), 64'(FLEN));
            prev_start = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge mclk);
    endtask

    task automatic bus(input logic do_re, input logic [15:0] ra, input logic ehit, input logic [15:0] edata,
                       input logic do_we, input logic [15:0] wa, input logic [15:0] wd);
        rd_exp_t e;
        @(posedge mclk); #1;
        re = do_re; raddr = ra; we = do_we; waddr = wa; wdata = wd;
        if (do_re) begin
            e.hit = ehit; e.data = edata;
            rd_q.push_back(e);
        end
        @(posedge mclk); #1;
        re = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic ehit, input logic [15:0] edata);
        bus(1'b1, a, ehit, edata, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, a, d);
    endtask

    task automatic exp_tx(input logic [7:0] d, input bit b2b);
        tx_exp_t e;
        e.data = d; e.b2b = b2b;
        tx_q.push_back(e);
    endtask

    initial begin
        // 1: reset values, then reset in the middle of a frame
        idle(3);
        #1 rst_n = 1'b1;
        wr(BASE, 16'h00A5);
        idle(12);
        #1 rst_n = 1'b0;
        #2;
        check("rst_tx", 64'(tx), 64'h1);
        check("rst_rd", 64'({rd_hit, rdata}), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        idle(3);
        #1 rst_n = 1'b1;
        rd(BASE + 16'd1, 1'b1, 16'h0002);

        // 2: single frame of 0x55, upper byte ignored
        exp_tx(8'h55, 0);
        wr(BASE, 16'h1255);
        idle(50);
        rd(BASE + 16'd1, 1'b1, 16'h0002);
        check("irq_ie0", 64'(irq), 64'h0);

        // 3: fill with transmitter disabled, ninth byte overflows
        wr(BASE + 16'd2, 16'h0000);
        for (int i = 1; i <= 9; i++) wr(BASE, {8'hAB, 8'(i)});
        for (int i = 1; i <= 8; i++) exp_tx(8'(i), i > 1);
        rd(BASE + 16'd1, 1'b1, 16'h0089);
        rd(BASE + 16'd1, 1'b1, 16'h0081);
        check("irq_full", 64'(irq), 64'h0);

        // 4: enable with interrupts -> eight contiguous frames
        wr(BASE + 16'd2, 16'h0003);
        idle(335);
        rd(BASE + 16'd1, 1'b1, 16'h0002);
        check("irq_done", 64'(irq), 64'h1);
        wr(BASE + 16'd2, 16'h0001);
        check("irq_ie_off", 64'(irq), 64'h0);

        // 5: same-cycle STATUS read and TXDATA write
        exp_tx(8'hA3, 0);
        bus(1'b1, BASE + 16'd1, 1'b1, 16'h0002, 1'b1, BASE, 16'h00A3);
        rd(BASE + 16'd1, 1'b1, 16'h0006);
        idle(45);

        // 6: window edges and CTRL masking
        rd(16'h00FF, 1'b0, 16'h0000);
        rd(BASE + 16'd3, 1'b1, 16'h0000);
        wr(BASE + 16'd2, 16'hFFFF);
        rd(BASE + 16'd2, 1'b1, 16'h0003);
        rd(BASE, 1'b1, 16'h0000);
        wr(16'hFE02, 16'h0000);
        wr(16'hFF06, 16'h0000);
        rd(BASE + 16'd2, 1'b1, 16'h0003);
        rd(16'hFF04, 1'b0, 16'h0000);
        check("irq_ctrl_ff", 64'(irq), 64'h1);

        idle(5);
        check("tx_q_drained", 64'(tx_q.size()), 64'h0);
        check("rd_q_drained", 64'(rd_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
